// File: rtl/prefix_subtractor_pipe.sv
// Pipelined parallel-prefix subtractor: diff = A - B - bin, evaluated as
// A + ~B + ~bin through a Kogge-Stone carry tree. Stage 0 registers the
// per-bit terms, stages 1..STAGES-1 each register one prefix level, and the
// last level is folded into the output register. Every rank shifts together
// under a single global advance, which gives a valid/ready handshake with
// backpressure.
module prefix_subtractor_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int STAGES = $clog2(WIDTH);

    // One Kogge-Stone level at span d: generate half of the (g,a) combine.
    function automatic logic [WIDTH-1:0] level_g(input logic [WIDTH-1:0] g,
                                                 input logic [WIDTH-1:0] a,
                                                 input int d);
        level_g = g;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= d) level_g[i] = g[i] | (a[i] & g[i-d]);
        end
    endfunction

    // Matching "alive" half of the combine.
    function automatic logic [WIDTH-1:0] level_a(input logic [WIDTH-1:0] a,
                                                 input int d);
        level_a = a;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= d) level_a[i] = a[i] & a[i-d];
        end
    endfunction

    // Per-stage datapath registers (index k = prefix level k).
    logic [WIDTH-1:0] g_q    [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] p_q    [STAGES];
    logic             cin_q  [STAGES];
    logic             amsb_q [STAGES];
    logic             bmsb_q [STAGES];
    logic [STAGES-1:0] vld_q;

    logic [WIDTH-1:0] g_d [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] g_last;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff_d;
    logic             advance;

    // The whole pipe moves only when the output slot is empty or being drained.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Next (g,a) for every stage: level 0 from the operands, level k from stage k-1.
    always_comb begin
        // NOTE: every always_comb output gets a full default before any
        // conditional update, so no path can leave a latch behind.
        for (int k = 0; k < STAGES; k++) begin
            g_d[k] = '0;
            a_d[k] = '0;
        end
        g_d[0] = A & ~B;
        a_d[0] = A | ~B;
        // Fold the carry-in (~bin) into bit 0 so the tree yields carries that
        // already include it: G[i] is then the carry out of bit i.
        g_d[0][0] = (A[0] & ~B[0]) | ((A[0] | ~B[0]) & ~bin);
        for (int k = 1; k < STAGES; k++) begin
            g_d[k] = level_g(g_q[k-1], a_q[k-1], 1 << (k - 1));
            a_d[k] = level_a(a_q[k-1], 1 << (k - 1));
        end
    end

    // Final prefix level and sum bits, computed ahead of the output register.
    always_comb begin
        g_last = level_g(g_q[STAGES-1], a_q[STAGES-1], WIDTH / 2);
        carry  = {g_last[WIDTH-2:0], cin_q[STAGES-1]};
        diff_d = p_q[STAGES-1] ^ carry;
    end

    // Datapath shift register: moves on advance, holds otherwise.
    always_ff @(posedge clock) begin
        // NOTE: intermediate data is qualified by vld_q, so it carries no reset;
        // only control bits and visible outputs are cleared.
        if (advance) begin
            g_q[0]    <= g_d[0];
            a_q[0]    <= a_d[0];
            p_q[0]    <= A ^ ~B;
            cin_q[0]  <= ~bin;
            amsb_q[0] <= A[WIDTH-1];
            bmsb_q[0] <= B[WIDTH-1];
            for (int k = 1; k < STAGES; k++) begin
                g_q[k]    <= g_d[k];
                a_q[k]    <= a_d[k];
                p_q[k]    <= p_q[k-1];
                cin_q[k]  <= cin_q[k-1];
                amsb_q[k] <= amsb_q[k-1];
                bmsb_q[k] <= bmsb_q[k-1];
            end
        end
    end

    // Valid bits and output register with synchronous reset; bubbles shift too.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every stage
        // samples the pre-edge value of its neighbour.
        if (!reset_n) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            vld_q     <= {vld_q[STAGES-2:0], in_valid};
            out_valid <= vld_q[STAGES-1];
            diff      <= diff_d;
            bout      <= ~g_last[WIDTH-1];
            zero      <= (diff_d == '0);
            ovf       <= (amsb_q[STAGES-1] != bmsb_q[STAGES-1]) &&
                         (diff_d[WIDTH-1] != amsb_q[STAGES-1]);
        end
    end

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Self-checking bench for prefix_subtractor_pipe: directed steps plus a
// random phase, with a queue scoreboard filled on input transfers and drained
// on output transfers.
module tb_prefix_subtractor_pipe;

    typedef struct packed {
        logic        bout;
        logic        zero;
        logic        ovf;
        logic [31:0] diff;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t got_e;
    exp_t hold_val;
    bit   hold_pend = 0;

    prefix_subtractor_pipe #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic bi);
        logic [32:0] w;
        exp_t        e;
        w      = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        e.diff = w[31:0];
        e.bout = w[32];
        e.zero = (w[31:0] == 32'd0);
        e.ovf  = (a[31] != b[31]) && (w[31] != a[31]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one operand set and hold it until the DUT accepts it.
    task automatic issue_exp(input logic [31:0] a, input logic [31:0] b,
                             input logic bi, input exp_t e);
        bit ok;
        A = a; B = b; bin = bi; cur_exp = e; in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clock);
            ok = in_ready;
            step();
            if (ok) break;
            if (t > 50) begin
                check("issue_timeout", ok, 1);
                break;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bi);
        issue_exp(a, b, bi, model(a, b, bi));
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            sb.delete();
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {bout, zero, ovf, diff}, hold_val);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    got_e = sb.pop_front();
                    check("result", {bout, zero, ovf, diff}, got_e);
                end
                n_out++;
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            hold_pend = out_valid && !out_ready;
            hold_val  = {bout, zero, ovf, diff};
        end
    end

    initial begin
        int  snap;
        bit  seen;
        exp_t e;

        // Reset, with in_valid asserted to show it is ignored.
        reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        A = 32'hdead_beef; B = 32'h1; bin = 1'b0; cur_exp = '0;
        step();
        step();
        @(negedge clock);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {bout, zero, ovf, diff}, 0);
        check("rst_in_ready", in_ready, 1);
        step();
        reset_n = 1'b1; in_valid = 1'b0;

        // Basic op and its exact latency.
        e = '{bout: 0, zero: 0, ovf: 0, diff: 32'h2};
        issue_exp(32'h5, 32'h3, 1'b0, e);
        in_valid = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clock);
            check("latency_basic", out_valid, (n == 6));
        end
        step();

        // Borrow, wrap, zero and signed overflow with hand-derived results.
        issue_exp(32'h0, 32'h1, 1'b0, '{1, 0, 0, 32'hFFFF_FFFF});
        issue_exp(32'h1234_5678, 32'h1234_5678, 1'b1, '{1, 0, 0, 32'hFFFF_FFFF});
        issue_exp(32'h1234_5678, 32'h1234_5678, 1'b0, '{0, 1, 0, 32'h0});
        issue_exp(32'h8000_0000, 32'h1, 1'b0, '{0, 0, 1, 32'h7FFF_FFFF});
        issue_exp(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{1, 0, 1, 32'h8000_0000});
        issue_exp(32'hCAFE_0001, 32'h0, 1'b0, '{0, 0, 0, 32'hCAFE_0001});
        in_valid = 1'b0;
        repeat (10) step();
        check("drain_directed", sb.size(), 0);

        // Ten back-to-back ops with out_ready held high.
        snap = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) issue(32'(i) * 32'h1111_1111, 32'(i), 1'b0);
                in_valid = 1'b0;
            end
            begin
                seen = 0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(negedge clock);
                    seen = out_valid;
                end
                check("stream_start", seen, 1);
                for (int k = 1; k < 10; k++) begin
                    @(negedge clock);
                    check("stream_run", out_valid, 1);
                end
                @(negedge clock);
                check("stream_end", out_valid, 0);
            end
        join
        repeat (8) step();
        check("stream_count", n_out - snap, 10);
        check("stream_empty", sb.size(), 0);

        // Same stream with a three-cycle consumer stall in the middle.
        snap = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) issue(32'(i) * 32'h1111_1111, 32'(i), 1'b0);
                in_valid = 1'b0;
            end
            begin
                seen = 0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(negedge clock);
                    seen = out_valid;
                end
                check("stall_start", seen, 1);
                step();
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    check("stall_in_ready", in_ready, 0);
                end
                step();
                out_ready = 1'b1;
            end
        join
        repeat (10) step();
        check("stall_count", n_out - snap, 10);
        check("stall_empty", sb.size(), 0);

        // Bubbles: in_valid 1,0,1,0 must reappear as out_valid 1,0,1,0.
        for (int c = 0; c <= 10; c++) begin
            A = 32'h100 + 32'(c); B = 32'h7 * 32'(c); bin = 1'(c);
            cur_exp = model(A, B, bin);
            in_valid = (c < 4) && (c % 2 == 0);
            @(negedge clock);
            check("bubble_pattern", out_valid, (c == 6 || c == 8));
            step();
        end
        in_valid = 1'b0;
        check("bubble_empty", sb.size(), 0);

        // Reset with three ops in flight; none may emerge afterwards.
        issue(32'h11, 32'h1, 1'b0);
        issue(32'h22, 32'h2, 1'b0);
        issue(32'h33, 32'h3, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; in_valid = 1'b0;
        @(negedge clock);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_outputs", {bout, zero, ovf, diff}, 0);
        check("midrst_in_ready", in_ready, 1);
        for (int n = 0; n < 7; n++) begin
            @(negedge clock);
            check("midrst_flushed", out_valid, 0);
        end
        step();
        issue(32'h9, 32'h4, 1'b1);
        in_valid = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clock);
            check("latency_after_rst", out_valid, (n == 6));
        end
        step();

        // Random operands, random in_valid and random backpressure.
        for (int i = 0; i < 10000; i++) begin
            A = $urandom; B = $urandom; bin = 1'($urandom_range(1));
            case ($urandom_range(7))
                0: B = A;
                1: A = 32'h0;
                2: B = 32'hFFFF_FFFF;
                3: A = 32'h8000_0000;
                default: ;
            endcase
            cur_exp   = model(A, B, bin);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) step();
        check("random_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
